issueq_free_list: RTL and testbench

//  Circular free list of issue-queue entry IDs; the consumer of the freed-entry stream from
//  the issue-queue freeing logic. Up to ISSUE_WIDTH freed IDs/cycle re-enter the list;

---
 rtl/issueq_free_list_pkg.sv | 22 ++
 rtl/issueq_free_list_compact.sv | 25 ++
 rtl/issueq_free_list.sv | 95 +++++++++
 tb/tb_issueq_free_list.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/issueq_free_list_pkg.sv
// Shared sizing, entry packet type and lane-count helper for the issue-queue free list.
package issueq_free_list_pkg;
   localparam int SIZE_ISSUEQ     = 32;
   localparam int SIZE_ISSUEQ_LOG = 5;
   localparam int ISSUE_WIDTH     = 4;
   localparam int DISPATCH_WIDTH  = 4;
   localparam int PKT_W           = SIZE_ISSUEQ_LOG + 1;
   localparam int FREE_CNT_W      = $clog2(ISSUE_WIDTH + 1);
   localparam int REQ_CNT_W       = $clog2(DISPATCH_WIDTH + 1);

   typedef struct packed {
      logic                       valid;
      logic [SIZE_ISSUEQ_LOG-1:0] id;
   } iqEntryPkt;

   function automatic logic [REQ_CNT_W-1:0] popcount_req(input logic [DISPATCH_WIDTH-1:0] v);
      logic [REQ_CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) c = c + REQ_CNT_W'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/issueq_free_list_compact.sv
// Packs the valid freed-entry lanes into consecutive slots (lane 0 first) and counts them.
module iq_free_compact
   import issueq_free_list_pkg::*;
(
   input  logic [ISSUE_WIDTH*PKT_W-1:0]           entries_i,
   output logic [ISSUE_WIDTH*SIZE_ISSUEQ_LOG-1:0] ids_o,
   output logic [FREE_CNT_W-1:0]                  cnt_o
);
   iqEntryPkt             pkt;
   logic [FREE_CNT_W-1:0] pos;

   always_comb begin
      ids_o = '0;
      pos   = '0;
      pkt   = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         pkt = entries_i[k*PKT_W +: PKT_W];
         if (pkt.valid) begin
            ids_o[pos*SIZE_ISSUEQ_LOG +: SIZE_ISSUEQ_LOG] = pkt.id;
            pos = pos + 1'b1;
         end
      end
      cnt_o = pos;
   end
endmodule

// File: rtl/issueq_free_list.sv
// Circular free list of issue-queue entry IDs: freed IDs enter at tail, dispatch pulls from head.
module issueq_free_list
   import issueq_free_list_pkg::*;
(
   input  logic                                      clk,
   input  logic                                      reset_n,
   input  logic [ISSUE_WIDTH*PKT_W-1:0]              freedEntry_i,
   input  logic [DISPATCH_WIDTH-1:0]                 allocReq_i,
   output logic [DISPATCH_WIDTH*SIZE_ISSUEQ_LOG-1:0] allocId_o,
   output logic                                      allocGrant_o,
   output logic                                      iqStall_o,
   output logic [SIZE_ISSUEQ_LOG:0]                  freeCnt_o,
   output logic                                      overflow_o
);
   localparam int CNT_W = SIZE_ISSUEQ_LOG + 1;
   localparam int SUM_W = SIZE_ISSUEQ_LOG + 2;

   logic [SIZE_ISSUEQ_LOG-1:0] list_q [SIZE_ISSUEQ];
   logic [SIZE_ISSUEQ_LOG-1:0] list_d [SIZE_ISSUEQ];
   logic [SIZE_ISSUEQ_LOG-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       ovf_q, ovf_d;

   logic [ISSUE_WIDTH*SIZE_ISSUEQ_LOG-1:0] cmpIds;
   logic [FREE_CNT_W-1:0]                  nFree;
   logic [REQ_CNT_W-1:0]                   reqCnt;
   logic                                   grant;
   logic [CNT_W-1:0]                       allocCnt;
   logic [SUM_W-1:0]                       nextSum;
   logic                                   ovfNow;
   logic [DISPATCH_WIDTH-1:0]              reqPlus1;

   iq_free_compact u_compact (
      .entries_i (freedEntry_i),
      .ids_o     (cmpIds),
      .cnt_o     (nFree)
   );

   always_comb begin
      reqCnt   = popcount_req(allocReq_i);
      grant    = (reqCnt != '0) && (cnt_q >= CNT_W'(reqCnt));
      allocCnt = grant ? CNT_W'(reqCnt) : '0;
      nextSum  = SUM_W'(cnt_q) - SUM_W'(allocCnt) + SUM_W'(nFree);
      ovfNow   = nextSum > SUM_W'(SIZE_ISSUEQ);

      head_d = head_q + SIZE_ISSUEQ_LOG'(allocCnt);
      list_d = list_q;
      tail_d = tail_q;
      cnt_d  = cnt_q - allocCnt;
      ovf_d  = ovf_q;
      // A free that would overfill the list is a double-free upstream: drop the whole write.
      if (ovfNow) begin
         ovf_d = 1'b1;
      end else begin
         for (int n = 0; n < ISSUE_WIDTH; n++) begin
            if (FREE_CNT_W'(n) < nFree)
               list_d[tail_q + SIZE_ISSUEQ_LOG'(n)] = cmpIds[n*SIZE_ISSUEQ_LOG +: SIZE_ISSUEQ_LOG];
         end
         tail_d = tail_q + SIZE_ISSUEQ_LOG'(nFree);
         cnt_d  = cnt_q - allocCnt + CNT_W'(nFree);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SIZE_ISSUEQ; i++) list_q[i] <= SIZE_ISSUEQ_LOG'(i);
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= CNT_W'(SIZE_ISSUEQ);
         ovf_q  <= 1'b0;
      end else begin
         list_q <= list_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   // Outputs present the post-reset state while reset_n is low.
   always_comb begin
      for (int k = 0; k < DISPATCH_WIDTH; k++)
         allocId_o[k*SIZE_ISSUEQ_LOG +: SIZE_ISSUEQ_LOG] =
            reset_n ? list_q[head_q + SIZE_ISSUEQ_LOG'(k)] : SIZE_ISSUEQ_LOG'(k);
      allocGrant_o = grant & reset_n;
      iqStall_o    = reset_n & (CNT_W'(reqCnt) > cnt_q);
      freeCnt_o    = reset_n ? cnt_q : CNT_W'(SIZE_ISSUEQ);
      overflow_o   = ovf_q & reset_n;
   end

   assign reqPlus1 = allocReq_i + 1'b1;

   a_req_thermometer : assert property (@(posedge clk) disable iff (!reset_n)
      (allocReq_i & reqPlus1) == '0);
endmodule

// File: tb/tb_issueq_free_list.sv
// Directed bench for issueq_free_list with queued expectations checked by an independent monitor.
module tb_issueq_free_list;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] freedEntry = '0;
   logic [3:0]  allocReq = '0;
   logic [19:0] allocId;
   logic        allocGrant, iqStall, overflow;
   logic [5:0]  freeCnt;

   typedef struct {
      int         tag;
      logic       grant;
      logic       stall;
      int         cnt;
      logic       ovf;
      logic [3:0] idmask;
      int         ids [4];
   } exp_t;

   exp_t sb [$];
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   done = 1'b0;

   issueq_free_list dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .freedEntry_i (freedEntry),
      .allocReq_i   (allocReq),
      .allocId_o    (allocId),
      .allocGrant_o (allocGrant),
      .iqStall_o    (iqStall),
      .freeCnt_o    (freeCnt),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int tag, input logic g, input logic s, input int c,
                               input logic o, input logic [3:0] m,
                               input int i0, input int i1, input int i2, input int i3);
      exp_t e;
      e.tag = tag; e.grant = g; e.stall = s; e.cnt = c; e.ovf = o; e.idmask = m;
      e.ids[0] = i0; e.ids[1] = i1; e.ids[2] = i2; e.ids[3] = i3;
      return e;
   endfunction

   task automatic drive(input logic rn, input logic [3:0] req, input logic [3:0] fv,
                        input int f0, input int f1, input int f2, input int f3, input exp_t e);
      @(posedge clk);
      #1;
      reset_n    = rn;
      allocReq   = req;
      freedEntry = {fv[3], 5'(f3), fv[2], 5'(f2), fv[1], 5'(f1), fv[0], 5'(f0)};
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         if (allocGrant !== e.grant) begin
            n_fail++; $display("FAIL grant tag=%0d got %b want %b", e.tag, allocGrant, e.grant);
         end
         n_cmp++;
         if (iqStall !== e.stall) begin
            n_fail++; $display("FAIL stall tag=%0d got %b want %b", e.tag, iqStall, e.stall);
         end
         n_cmp++;
         if (freeCnt !== 6'(e.cnt)) begin
            n_fail++; $display("FAIL freeCnt tag=%0d got %0d want %0d", e.tag, freeCnt, e.cnt);
         end
         n_cmp++;
         if (overflow !== e.ovf) begin
            n_fail++; $display("FAIL overflow tag=%0d got %b want %b", e.tag, overflow, e.ovf);
         end
         for (int k = 0; k < 4; k++) begin
            if (e.idmask[k]) begin
               n_cmp++;
               if (allocId[k*5 +: 5] !== 5'(e.ids[k])) begin
                  n_fail++;
                  $display("FAIL allocId[%0d] tag=%0d got %0d want %0d", k, e.tag,
                           allocId[k*5 +: 5], e.ids[k]);
               end
            end
         end
      end
   end

   initial begin
      // Reset: requests ignored, outputs show reset state
      drive(0, 4'b1111, 4'b0000, 0, 0, 0, 0, mk(1, 0, 0, 32, 0, 4'hF, 0, 1, 2, 3));
      drive(0, 4'b1111, 4'b0000, 0, 0, 0, 0, mk(2, 0, 0, 32, 0, 4'hF, 0, 1, 2, 3));
      drive(1, 4'b0000, 4'b0000, 0, 0, 0, 0, mk(3, 0, 0, 32, 0, 4'hF, 0, 1, 2, 3));
      // Drain the whole list in order, then stall on empty
      for (int j = 0; j < 8; j++)
         drive(1, 4'b1111, 4'b0000, 0, 0, 0, 0,
               mk(10 + j, 1, 0, 32 - 4*j, 0, 4'hF, 4*j, 4*j + 1, 4*j + 2, 4*j + 3));
      drive(1, 4'b1111, 4'b0000, 0, 0, 0, 0, mk(20, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0));
      // Free with holes into empty list
      drive(1, 4'b0000, 4'b1010, 0, 7, 0, 12, mk(30, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      drive(1, 4'b0111, 4'b0000, 0, 0, 0, 0, mk(31, 0, 1, 2, 0, 4'h3, 7, 12, 0, 0));
      drive(1, 4'b0011, 4'b0000, 0, 0, 0, 0, mk(32, 1, 0, 2, 0, 4'h3, 7, 12, 0, 0));
      // Simultaneous free + alloc, no bypass
      drive(1, 4'b0000, 4'b0011, 20, 21, 0, 0, mk(40, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      drive(1, 4'b0011, 4'b0101, 5, 0, 9, 0, mk(41, 1, 0, 2, 0, 4'h3, 20, 21, 0, 0));
      drive(1, 4'b0011, 4'b0000, 0, 0, 0, 0, mk(42, 1, 0, 2, 0, 4'h3, 5, 9, 0, 0));
      // Stream through pointer wrap: head reaches 30 at i=7
      drive(1, 4'b0000, 4'b1111, 0, 1, 2, 3, mk(50, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      for (int i = 1; i < 8; i++)
         drive(1, 4'b1111, 4'b1111, 4*i, 4*i + 1, 4*i + 2, 4*i + 3,
               mk(50 + i, 1, 0, 4, 0, 4'hF, 4*(i-1), 4*(i-1) + 1, 4*(i-1) + 2, 4*(i-1) + 3));
      drive(1, 4'b1111, 4'b0000, 0, 0, 0, 0, mk(58, 1, 0, 4, 0, 4'hF, 28, 29, 30, 31));
      // Fill to 31, then overflow
      for (int c = 0; c < 8; c++)
         drive(1, 4'b0000, (c < 7) ? 4'b1111 : 4'b1011, 31 - 4*c, 30 - 4*c, 29 - 4*c, 28 - 4*c,
               mk(60 + c, 0, 0, 4*c, 0, 4'h0, 0, 0, 0, 0));
      drive(1, 4'b0000, 4'b0011, 1, 2, 0, 0, mk(70, 0, 0, 31, 0, 4'h0, 0, 0, 0, 0));
      drive(1, 4'b0001, 4'b0000, 0, 0, 0, 0, mk(71, 1, 0, 31, 1, 4'h1, 31, 0, 0, 0));
      drive(1, 4'b0000, 4'b0000, 0, 0, 0, 0, mk(72, 0, 0, 30, 1, 4'h0, 0, 0, 0, 0));
      // Reset clears overflow and restores the full list
      drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, mk(80, 0, 0, 32, 0, 4'hF, 0, 1, 2, 3));
      drive(1, 4'b0000, 4'b0000, 0, 0, 0, 0, mk(81, 0, 0, 32, 0, 4'hF, 0, 1, 2, 3));
      drive(1, 4'b1111, 4'b0000, 0, 0, 0, 0, mk(82, 1, 0, 32, 0, 4'hF, 0, 1, 2, 3));
      @(posedge clk);
      #1;
      allocReq = '0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      done = 1'b1;
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL timeout got no completion want completion");
         $fatal(1);
      end
   end
endmodule
